// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants, coordinate widths and total-length helpers
// for the VGA scan timer and its axis counters.
package vga_pkg;

    localparam int WIDTH_DEF   = 640;
    localparam int HEIGHT_DEF  = 480;
    localparam int H_FP_DEF    = 16;
    localparam int H_SYNC_DEF  = 96;
    localparam int H_BP_DEF    = 48;
    localparam int V_FP_DEF    = 10;
    localparam int V_SYNC_DEF  = 2;
    localparam int V_BP_DEF    = 33;
    localparam int CLK_DIV_DEF = 2;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int CNT_W = 10;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on each advance and decodes the active
// and sync windows of the count currently held.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = WIDTH_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic             active,
    output logic             sync_n,
    output logic             wrap
);

    localparam int TOTAL = h_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACTIVE_END = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

    // wrap is qualified by advance so it can directly chain the next axis
    assign wrap   = advance && (count == LAST);
    assign active = (count < ACTIVE_END);
    assign sync_n = !((count >= SYNC_START) && (count < SYNC_END));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (advance) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_scan_timer.sv
// VGA raster timer and pixel sink: publishes (x, y), registers the returned colour
// with aligned sync/blank. Define VGA_BORDER_EN to force a white alignment border.
module vga_scan_timer
    import vga_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int HEIGHT  = HEIGHT_DEF,
    parameter int H_FP    = H_FP_DEF,
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BP    = H_BP_DEF,
    parameter int V_FP    = V_FP_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BP    = V_BP_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic           clk,
    input  logic           reset,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    input  logic [7:0]     r,
    input  logic [7:0]     g,
    input  logic [7:0]     b,
    output logic [7:0]     VGA_R,
    output logic [7:0]     VGA_G,
    output logic [7:0]     VGA_B,
    output logic           VGA_CLK,
    output logic           VGA_HS,
    output logic           VGA_VS,
    output logic           VGA_BLANK_N,
    output logic           VGA_SYNC_N,
    output logic           frame_start
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(HEIGHT - 1);

    logic [DIV_W-1:0] div;
    logic             pix_en;
    logic [CNT_W-1:0] hcount, vcount;
    logic             h_active, v_active, h_sync_n, v_sync_n, h_wrap, v_wrap;
    logic             active, border;
    logic [7:0]       col_r, col_g, col_b;

    assign pix_en     = (div == DIV_LAST);
    assign active     = h_active && v_active;
    assign VGA_SYNC_N = 1'b0;

    vga_axis_counter #(
        .ACTIVE (WIDTH),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk     (clk),
        .reset   (reset),
        .advance (pix_en),
        .count   (hcount),
        .active  (h_active),
        .sync_n  (h_sync_n),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (HEIGHT),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk     (clk),
        .reset   (reset),
        .advance (h_wrap),
        .count   (vcount),
        .active  (v_active),
        .sync_n  (v_sync_n),
        .wrap    (v_wrap)
    );

    assign x = h_active ? hcount[X_W-1:0] : '0;
    assign y = v_active ? vcount[Y_W-1:0] : '0;

    always_comb begin
        border = 1'b0;
`ifdef VGA_BORDER_EN
        border = active && ((hcount == '0) || (hcount == X_LAST) ||
                            (vcount == '0) || (vcount == Y_LAST));
`endif
        col_r = border ? 8'hFF : r;
        col_g = border ? 8'hFF : g;
        col_b = border ? 8'hFF : b;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else begin
            div <= pix_en ? '0 : div + 1'b1;
        end
    end

    // DAC clock falls as a pixel is launched and rises half a pixel later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            VGA_CLK <= 1'b0;
        end else if (pix_en) begin
            VGA_CLK <= 1'b0;
        end else if (div == DIV_HALF) begin
            VGA_CLK <= 1'b1;
        end
    end

    // Outputs describe the pixel being left, so colour/sync/blank stay aligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
        end else if (pix_en) begin
            VGA_R       <= active ? col_r : 8'h00;
            VGA_G       <= active ? col_g : 8'h00;
            VGA_B       <= active ? col_b : 8'h00;
            VGA_HS      <= h_sync_n;
            VGA_VS      <= v_sync_n;
            VGA_BLANK_N <= active;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_scan_timer.sv
// Directed bench for vga_scan_timer: default horizontal timing, shortened vertical
// timing (6 active lines, 11 total) so whole frames fit in a short run.
module tb_vga_scan_timer;

    localparam int HT     = 6;
    localparam int VFP_T  = 1;
    localparam int VSY_T  = 2;
    localparam int VBP_T  = 2;
    localparam int WIDTH  = 640;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] r, g, b;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx = 0, ty = 0;
    int max_x = 0, max_y = 0;

    vga_scan_timer #(
        .HEIGHT (HT),
        .V_FP   (VFP_T),
        .V_SYNC (VSY_T),
        .V_BP   (VBP_T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .r           (r),
        .g           (g),
        .b           (b),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_CLK     (VGA_CLK),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .frame_start (frame_start)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel-colour requester: one clock behind x/y
`ifdef VGA_BORDER_EN
    initial begin
        r = 8'h00;
        g = 8'h00;
        b = 8'h00;
    end
`else
    always @(posedge clk) begin
        r <= x[7:0];
        g <= y[7:0];
        b <= 8'h5A;
    end
`endif

    always @(negedge clk) begin
        if (!reset) begin
            if (int'(x) > max_x) max_x = int'(x);
            if (int'(y) > max_y) max_y = int'(y);
        end
    end

    function automatic logic [23:0] exp_pix(input int px, input int py);
`ifdef VGA_BORDER_EN
        if (px == 0 || px == WIDTH - 1 || py == 0 || py == HT - 1) return 24'hFFFFFF;
        return 24'h000000;
`else
        return {px[7:0], py[7:0], 8'h5A};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0: return x == 10'd1;
            1: return !VGA_HS;
            2: return VGA_HS;
            3: return !VGA_VS;
            4: return VGA_VS;
            5: return frame_start;
            6: return (int'(x) == tx) && (int'(y) == ty);
            default: return 1'b1;
        endcase
    endfunction

    task automatic wait_cond(input int sel, input int limit, input string tag);
        int n = 0;
        while (!cond(sel) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_reached"}, 32'(cond(sel)), 32'd1);
    endtask

    task automatic check_pixel(input int px, input int py, input string tag);
        logic [23:0] e;
        tx = px;
        ty = py;
        wait_cond(6, 20000, tag);
        repeat (2) @(negedge clk);
        e = exp_pix(px, py);
        chk({tag, "_r"}, 32'(VGA_R), 32'(e[23:16]));
        chk({tag, "_g"}, 32'(VGA_G), 32'(e[15:8]));
        chk({tag, "_b"}, 32'(VGA_B), 32'(e[7:0]));
        chk({tag, "_blank_n"}, 32'(VGA_BLANK_N), 32'd1);
    endtask

    initial begin
        int t_rel, t0, t1, t2, t3;
        int rise_at, fall_at, blank_cnt;

        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_vga_r", 32'(VGA_R), 0);
        chk("rst_vga_g", 32'(VGA_G), 0);
        chk("rst_vga_b", 32'(VGA_B), 0);
        chk("rst_hs", 32'(VGA_HS), 1);
        chk("rst_vs", 32'(VGA_VS), 1);
        chk("rst_blank_n", 32'(VGA_BLANK_N), 0);
        chk("rst_vga_clk", 32'(VGA_CLK), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("sync_n_rst", 32'(VGA_SYNC_N), 0);

        // Line timing
        reset = 1'b0;
        t_rel = cyc;
        wait_cond(0, 10, "first_pix");
        t0 = cyc;
        chk("first_pix_latency", 32'(t0 - t_rel), 2);
        chk("vga_clk_low_at_pix_en", 32'(VGA_CLK), 0);
        @(negedge clk);
        chk("vga_clk_high_mid_pixel", 32'(VGA_CLK), 1);

        wait_cond(1, 2000, "hs_fall");
        t1 = cyc;
        chk("hs_first_fall", 32'(t1 - t0), 1312);
        rise_at = -1;
        fall_at = -1;
        blank_cnt = 0;
        for (int i = 1; i <= 1600; i++) begin
            @(negedge clk);
            if (VGA_BLANK_N) blank_cnt++;
            if (VGA_HS && rise_at < 0) rise_at = i;
            if (!VGA_HS && rise_at >= 0 && fall_at < 0) fall_at = i;
        end
        chk("hs_low_clks", 32'(rise_at), 192);
        chk("hs_period", 32'(fall_at), 1600);
        chk("blank_n_high_per_line", 32'(blank_cnt), 1280);
        chk("sync_n_run", 32'(VGA_SYNC_N), 0);

        // Colour path
        check_pixel(100, 2, "pix_100_2");
        check_pixel(639, 3, "pix_639_3");
        check_pixel(0, 4, "pix_0_4");
        check_pixel(320, 4, "pix_320_4");
        check_pixel(5, HT - 1, "pix_5_last");
        wait_cond(1, 2000, "hs_line5");
        chk("blank_vga_r", 32'(VGA_R), 0);
        chk("blank_vga_g", 32'(VGA_G), 0);
        chk("blank_vga_b", 32'(VGA_B), 0);
        chk("blank_blank_n", 32'(VGA_BLANK_N), 0);

        // Frame timing: VS over lines 7..8, frame = 800*11*2 clk
        wait_cond(3, 20000, "vs_fall");
        t2 = cyc;
        chk("vs_fall_time", 32'(t2 - t0), 11200);
        wait_cond(4, 5000, "vs_rise");
        chk("vs_low_clks", 32'(cyc - t2), 3200);
        wait_cond(5, 10000, "fs_first");
        t3 = cyc;
        chk("fs_first_time", 32'(t3 - t0), 17598);
        chk("fs_x", 32'(x), 0);
        chk("fs_y", 32'(y), 0);
        @(negedge clk);
        chk("fs_one_clk", 32'(frame_start), 0);
        check_pixel(10, 0, "pix_10_0");
        wait_cond(5, 20000, "fs_second");
        chk("fs_period", 32'(cyc - t3), 17600);
        chk("max_x", 32'(max_x), 639);
        chk("max_y", 32'(max_y), HT - 1);

        // Mid-frame asynchronous reset
        tx = 300;
        ty = 3;
        wait_cond(6, 20000, "mid_pos");
        reset = 1'b1;
        #1;
        chk("mid_x", 32'(x), 0);
        chk("mid_y", 32'(y), 0);
        chk("mid_vga_r", 32'(VGA_R), 0);
        chk("mid_vga_g", 32'(VGA_G), 0);
        chk("mid_vga_b", 32'(VGA_B), 0);
        chk("mid_blank_n", 32'(VGA_BLANK_N), 0);
        chk("mid_hs", 32'(VGA_HS), 1);
        chk("mid_vs", 32'(VGA_VS), 1);
        chk("mid_vga_clk", 32'(VGA_CLK), 0);
        chk("mid_frame_start", 32'(frame_start), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        t_rel = cyc;
        wait_cond(0, 10, "restart_pix");
        t0 = cyc;
        chk("restart_latency", 32'(t0 - t_rel), 2);
        chk("restart_y", 32'(y), 0);
        wait_cond(5, 20000, "fs_after_reset");
        chk("fs_after_reset_time", 32'(cyc - t0), 17598);
        chk("sync_n_end", 32'(VGA_SYNC_N), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_scan_timer.md
Name: vga_scan_timer

Overview:
- VGA raster timing generator and pixel sink for the 640x480 display path.
- Produces the scan coordinates (x, y) consumed by the game's pixel-colour logic.
- Samples the returned r/g/b and drives the VGA DAC pins with aligned sync and blanking.
- Sits between the top-level screen-drawing logic and the board VGA connector; it is the driver end of the x/y -> r/g/b interface.

Parameters:
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (even, >=2)

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  asynchronous, active-high reset
- x  out  10  current active column; 0 outside active region
- y  out  9  current active row; 0 outside active region
- r, g, b  in  8 each  pixel colour for the current (x, y); must be valid within CLK_DIV clk cycles of x/y changing
- VGA_R, VGA_G, VGA_B  out  8 each  DAC colour data
- VGA_CLK  out  1  pixel clock to DAC
- VGA_HS, VGA_VS  out  1 each  active-low syncs
- VGA_BLANK_N  out  1  low outside active region
- VGA_SYNC_N  out  1  tied 0
- frame_start  out  1  one-clk pulse when a new frame begins

Behaviour:
- Derived totals: H_TOTAL = WIDTH+H_FP+H_SYNC+H_BP (800); V_TOTAL = HEIGHT+V_FP+V_SYNC+V_BP (525).
- hcount and vcount are 10-bit registers.
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_en = (div == CLK_DIV-1).
- VGA_CLK is registered:
  - driven 0 on the pix_en edge;
  - driven 1 on the edge CLK_DIV/2 clocks later;
  - so its rising edge falls mid-pixel, while data is stable.
- Counter update on pix_en:
  - hcount increments; at H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps from V_TOTAL-1 to 0.
  - All other cycles hold.
- x = hcount when hcount < WIDTH, else 0. y = vcount[8:0] when vcount < HEIGHT, else 0. Both are direct from registers (no combinational path from inputs).
- Output stage, on the pix_en edge, registered from the counter values being left (the pre-increment values):
  - VGA_R/G/B <= active ? r/g/b : 0
  - VGA_BLANK_N <= active
  - VGA_HS <= ~(hcount in [WIDTH+H_FP, WIDTH+H_FP+H_SYNC))
  - VGA_VS <= ~(vcount in [HEIGHT+V_FP, HEIGHT+V_FP+V_SYNC))
- Latency: colour, sync and blank for a pixel appear together one pixel period after x/y present it. The requester's r/g/b latency must be <= CLK_DIV clocks.
- frame_start: high for exactly one clk, in the cycle after the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0). Not asserted out of reset.
- Reset (async, any time including mid-frame):
  - div=0, hcount=0, vcount=0, x=0, y=0
  - VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_CLK=0, frame_start=0
  - Scan restarts at (0,0) on the first pix_en after release.
- VGA_SYNC_N is constant 0 in all states.

Optional Feature:
- Macro: VGA_BORDER_EN.
- Defined: pixels with x==0, x==WIDTH-1, y==0 or y==HEIGHT-1 output 0xFF on all three colours, overriding r/g/b. Used for monitor alignment.
- Undefined: r/g/b pass through unmodified. Identical ports in both builds.

Decomposition:
- Shared package vga_pkg holds:
  - default timing constants (640x480@60)
  - derived H_TOTAL/V_TOTAL functions
  - the coordinate widths (10/9)
- One sub-module, vga_axis_counter, instantiated twice (horizontal and vertical):
  - parameterised ACTIVE/FP/SYNC/BP;
  - advance enable input;
  - outputs count, active, sync_n, wrap.

Test Plan:
- Reset values: hold reset 5 clk -> all outputs at reset values; VGA_SYNC_N=0 throughout.
- Line timing: release reset. VGA_HS first falls 656*2=1312 clk after the first pix_en, stays low 192 clk, and repeats every 1600 clk. VGA_BLANK_N is high exactly 1280 clk per line.
- Frame timing: VGA_VS low for lines 490-491 (2 lines = 3200 clk). frame_start period = 840000 clk. y reaches 479 and never exceeds it; x never exceeds 639.
- Colour path: drive r=x[7:0], g=y[7:0], b=0x5A (2-clk registered model). VGA_R at active pixel (100,200) reads 100, VGA_G reads 200, VGA_B reads 0x5A. Colour outputs are 0 while blanked.
- VGA_BORDER_EN build: drive r=g=b=0. Pixels (0,k), (639,k), (k,0), (k,479) read 0xFF; pixel (320,240) reads 0.
- Mid-frame reset: assert reset at (300,150) -> outputs return to reset values immediately (asynchronously). After release, x/y restart from (0,0) and no frame_start is seen until the next full wrap.
